// File: rtl/imem_loader_pkg.sv
// Shared FSM state encodings and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    localparam int LD_ST_W           = 3;
    localparam int LD_BYTES_PER_WORD = 4;

    localparam logic [LD_ST_W-1:0] LD_IDLE = 3'd0;
    localparam logic [LD_ST_W-1:0] LD_LEN  = 3'd1;
    localparam logic [LD_ST_W-1:0] LD_LOAD = 3'd2;
    localparam logic [LD_ST_W-1:0] LD_CHK  = 3'd3;
    localparam logic [LD_ST_W-1:0] LD_DONE = 3'd4;
    localparam logic [LD_ST_W-1:0] LD_ERR  = 3'd5;

    // States in which the loader consumes stream bytes.
    function automatic logic ld_active(input logic [LD_ST_W-1:0] st);
        return (st == LD_LEN) || (st == LD_LOAD) || (st == LD_CHK);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian 4-byte collector: the word and its valid pulse are presented combinationally
// alongside the 4th byte so the consumer can register the word on that same edge.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        byte_vld,
    output logic [31:0] word,
    output logic        word_vld
);

    localparam logic [1:0] LAST_IDX = 2'(LD_BYTES_PER_WORD - 1);

    logic [1:0]  idx;
    logic [23:0] low;

    assign word_vld = byte_vld && (idx == LAST_IDX);
    assign word     = {byte_in, low};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= 2'd0;
            low <= 24'd0;
        end else if (clear) begin
            idx <= 2'd0;
        end else if (byte_vld) begin
            idx <= idx + 2'd1;
            case (idx)
                2'd0:    low[7:0]   <= byte_in;
                2'd1:    low[15:8]  <= byte_in;
                2'd2:    low[23:16] <= byte_in;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction BRAM writer fed by a length-prefixed little-endian byte stream.
// Optional trailing-checksum verification is enabled by defining LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          MAX_WORDS = 1024,
    parameter int          CNT_W     = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [31:0]      i_w_addr,
    output logic [31:0]      i_w_dat,
    output logic             i_w_enb,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] words_loaded
);

    logic [LD_ST_W-1:0] state;
    logic [CNT_W-1:0]   len_words;
    logic [31:0]        word;
    logic               word_vld;
    logic               start_ok;
    logic               last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]        acc;
`endif

    assign rx_ready  = ld_active(state);
    assign busy      = ld_active(state);
    assign start_ok  = start && !ld_active(state);
    assign last_word = (words_loaded + CNT_W'(1)) == len_words;

    byte_packer u_packer (
        .clk      (clk),
        .rst_n    (rst),
        .clear    (start_ok),
        .byte_in  (rx_data),
        .byte_vld (rx_valid && rx_ready),
        .word     (word),
        .word_vld (word_vld)
    );

    // State advances on the edge that completes a field; the write pulse lands the cycle after.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= LD_IDLE;
            cpu_hold     <= 1'b1;
            i_w_enb      <= 1'b0;
            i_w_addr     <= BASE_ADDR;
            i_w_dat      <= 32'd0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            len_words    <= '0;
`ifdef LOADER_CHECKSUM_EN
            acc          <= 32'd0;
`endif
        end else begin
            i_w_enb <= 1'b0;
            if (start_ok) begin
                state        <= LD_LEN;
                cpu_hold     <= 1'b1;
                done         <= 1'b0;
                err          <= 1'b0;
                words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
                acc          <= 32'd0;
`endif
            end else if (word_vld) begin
                case (state)
                    LD_LEN: begin
                        if (word == 32'd0) begin
                            state    <= LD_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else if (word > 32'(MAX_WORDS)) begin
                            state <= LD_ERR;
                            err   <= 1'b1;
                        end else begin
                            state     <= LD_LOAD;
                            len_words <= word[CNT_W-1:0];
                        end
                    end
                    LD_LOAD: begin
                        i_w_enb      <= 1'b1;
                        i_w_addr     <= BASE_ADDR + (32'(words_loaded) << 2);
                        i_w_dat      <= word;
                        words_loaded <= words_loaded + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
                        acc          <= acc + word;
                        if (last_word) state <= LD_CHK;
`else
                        if (last_word) begin
                            state    <= LD_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end
`endif
                    end
`ifdef LOADER_CHECKSUM_EN
                    LD_CHK: begin
                        if (word == acc) begin
                            state    <= LD_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= LD_ERR;
                            err   <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule
